// File: rtl/vector_floating_point_writeback_stage_if.sv
// vector_floating_point_writeback_stage_if: multiply-result input and register-file write handshake bundle
interface vector_floating_point_writeback_stage_if #(parameter int ADDRESS_WIDTH = 5);
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_widening;
  logic [ADDRESS_WIDTH-1:0] in_vd_index;
  logic [63:0]              vd;
  logic [63:0]              vd_high;
  logic                     out_valid;
  logic                     out_ready;
  logic [ADDRESS_WIDTH-1:0] out_address;
  logic [63:0]              out_data;
  logic                     out_last;
  modport master (
    output in_valid, in_widening, in_vd_index, vd, vd_high, out_ready,
    input  in_ready, out_valid, out_address, out_data, out_last
  );
  modport slave (
    input  in_valid, in_widening, in_vd_index, vd, vd_high, out_ready,
    output in_ready, out_valid, out_address, out_data, out_last
  );
endinterface

// File: rtl/vector_floating_point_writeback_stage.sv
// vector_floating_point_writeback_stage: serialises FP multiply results into 64-bit register file writes.
// Optional write counter output enabled by defining DRAGONFANG_WRITEBACK_COUNTER_EN.
module vector_floating_point_writeback_stage #(
  parameter int ADDRESS_WIDTH = 5
) (
  input logic clock,
  input logic reset_n,
  vector_floating_point_writeback_stage_if.slave bus
`ifdef DRAGONFANG_WRITEBACK_COUNTER_EN
  ,
  output logic [31:0] write_count
`endif
);
  typedef enum logic [1:0] {IDLE, EMIT_LOW, EMIT_HIGH} state_t;
  state_t                   state;
  logic [63:0]              data_low;
  logic [63:0]              data_high;
  logic [ADDRESS_WIDTH-1:0] index;
  logic                     widening;
  logic                     accept;
  // Ready is a function of state and downstream ready only, so a new result can slip in on the final write
  assign bus.in_ready = (state == IDLE) |
                        ((state == EMIT_LOW) & ~widening & bus.out_ready) |
                        ((state == EMIT_HIGH) & bus.out_ready);
  assign accept = bus.in_valid & bus.in_ready;
  // FSM with registered write outputs; a new accept always starts with the low write
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      data_low        <= '0;
      data_high       <= '0;
      index           <= '0;
      widening        <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.out_data    <= '0;
      bus.out_address <= '0;
      bus.out_last    <= 1'b0;
    end else if (accept) begin
      state           <= EMIT_LOW;
      data_low        <= bus.vd;
      index           <= bus.in_vd_index;
      widening        <= bus.in_widening;
      if (bus.in_widening) data_high <= bus.vd_high;
      bus.out_valid   <= 1'b1;
      bus.out_data    <= bus.vd;
      bus.out_address <= bus.in_vd_index;
      bus.out_last    <= ~bus.in_widening;
    end else if (state == EMIT_LOW && bus.out_ready && widening) begin
      state           <= EMIT_HIGH;
      bus.out_data    <= data_high;
      bus.out_address <= index + 1'b1;
      bus.out_last    <= 1'b1;
    end else if (state != IDLE && bus.out_ready) begin
      state           <= IDLE;
      bus.out_valid   <= 1'b0;
      bus.out_data    <= '0;
      bus.out_address <= '0;
      bus.out_last    <= 1'b0;
    end
  end
`ifdef DRAGONFANG_WRITEBACK_COUNTER_EN
  // Counts completed register file writes, wrapping naturally at 32 bits
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) write_count <= '0;
    else if (bus.out_valid && bus.out_ready) write_count <= write_count + 32'd1;
  end
`endif
endmodule

// File: tb/tb_vector_floating_point_writeback_stage.sv
// tb_vector_floating_point_writeback_stage: directed plan plus randomized traffic against a write-queue model
module tb_vector_floating_point_writeback_stage;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  vector_floating_point_writeback_stage_if #(.ADDRESS_WIDTH(5)) bus ();
`ifdef DRAGONFANG_WRITEBACK_COUNTER_EN
  logic [31:0] write_count;
  vector_floating_point_writeback_stage #(.ADDRESS_WIDTH(5)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus.slave), .write_count(write_count));
`else
  vector_floating_point_writeback_stage #(.ADDRESS_WIDTH(5)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus.slave));
`endif
  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0]  address;
    logic [63:0] data;
    logic        last;
  } write_t;
  write_t pending[$];
  int unsigned model_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the stage holds an ordered list of writes still owed to the register file
  always @(negedge clock) begin
    if (!reset_n) begin
      pending.delete();
      model_count = 0;
      chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    end else begin
      logic   exp_ready;
      write_t head;
      head = pending.size() != 0 ? pending[0] : '0;
      exp_ready = pending.size() == 0 || (pending.size() == 1 && bus.out_ready);
      chk("m_out_valid", {63'd0, bus.out_valid}, {63'd0, pending.size() != 0});
      chk("m_out_address", {59'd0, bus.out_address}, {59'd0, head.address});
      chk("m_out_data", bus.out_data, head.data);
      chk("m_out_last", {63'd0, bus.out_last}, {63'd0, head.last});
      chk("m_in_ready", {63'd0, bus.in_ready}, {63'd0, exp_ready});
`ifdef DRAGONFANG_WRITEBACK_COUNTER_EN
      chk("m_write_count", {32'd0, write_count}, {32'd0, model_count});
`endif
      if (pending.size() != 0 && bus.out_ready) begin
        void'(pending.pop_front());
        model_count++;
      end
      if (bus.in_valid && exp_ready) begin
        pending.push_back('{bus.in_vd_index, bus.vd, ~bus.in_widening});
        if (bus.in_widening) pending.push_back('{bus.in_vd_index + 5'd1, bus.vd_high, 1'b1});
      end
    end
  end

  task automatic step(input logic v, input logic w, input logic [4:0] idx,
                      input logic [63:0] lo, input logic [63:0] hi, input logic ordy);
    @(posedge clock);
    #1;
    bus.in_valid = v;
    bus.in_widening = w;
    bus.in_vd_index = idx;
    bus.vd = lo;
    bus.vd_high = hi;
    bus.out_ready = ordy;
    @(negedge clock);
  endtask

  task automatic chk_out(input string name, input logic v, input logic [4:0] a,
                         input logic [63:0] d, input logic l);
    chk({name, "_valid"}, {63'd0, bus.out_valid}, {63'd0, v});
    chk({name, "_address"}, {59'd0, bus.out_address}, {59'd0, a});
    chk({name, "_data"}, bus.out_data, d);
    chk({name, "_last"}, {63'd0, bus.out_last}, {63'd0, l});
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_widening = 1'b0;
    bus.in_vd_index = '0;
    bus.vd = '0;
    bus.vd_high = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clock);
    chk_out("reset", 1'b0, 5'd0, 64'd0, 1'b0);
    chk("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
`ifdef DRAGONFANG_WRITEBACK_COUNTER_EN
    chk("reset_count", {32'd0, write_count}, 64'd0);
`endif
    @(posedge clock);
    #1 reset_n = 1'b1;
    // non-widening single write
    step(1, 0, 5'd3, 64'h3FF0000000000000, 64'hDEAD, 1);
    chk("nw_in_ready", {63'd0, bus.in_ready}, 64'd1);
    step(0, 0, 5'd0, 64'd0, 64'd0, 1);
    chk_out("nw", 1'b1, 5'd3, 64'h3FF0000000000000, 1'b1);
    step(0, 0, 5'd0, 64'd0, 64'd0, 1);
    chk_out("nw_idle", 1'b0, 5'd0, 64'd0, 1'b0);
    // widening pair with back-pressure on the high write
    step(1, 1, 5'd6, 64'h4000000000000000, 64'h4008000000000000, 1);
    step(0, 0, 5'd0, 64'd0, 64'd0, 1);
    chk_out("w_low", 1'b1, 5'd6, 64'h4000000000000000, 1'b0);
    chk("w_low_in_ready", {63'd0, bus.in_ready}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 5'd1, 64'h1111, 64'd0, 0);
      chk_out("bp_high", 1'b1, 5'd7, 64'h4008000000000000, 1'b1);
      chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
    end
    step(1, 0, 5'd9, 64'hAAAA5555AAAA5555, 64'd0, 1);
    chk_out("rel_high", 1'b1, 5'd7, 64'h4008000000000000, 1'b1);
    chk("rel_in_ready", {63'd0, bus.in_ready}, 64'd1);
    step(0, 0, 5'd0, 64'd0, 64'd0, 1);
    chk_out("rel_next", 1'b1, 5'd9, 64'hAAAA5555AAAA5555, 1'b1);
    // address wrap on widening high half
    step(1, 1, 5'd31, 64'h5, 64'h6, 1);
    step(0, 0, 5'd0, 64'd0, 64'd0, 1);
    chk_out("wrap_low", 1'b1, 5'd31, 64'h5, 1'b0);
    step(0, 0, 5'd0, 64'd0, 64'd0, 1);
    chk_out("wrap_high", 1'b1, 5'd0, 64'h6, 1'b1);
    // streaming back-to-back
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 5'(10 + i), 64'(100 + i), 64'd0, 1);
      chk("st_in_ready", {63'd0, bus.in_ready}, 64'd1);
      if (i > 0) chk_out("st", 1'b1, 5'(9 + i), 64'(99 + i), 1'b1);
    end
    step(0, 0, 5'd0, 64'd0, 64'd0, 1);
    chk_out("st_last", 1'b1, 5'd13, 64'd103, 1'b1);
    step(0, 0, 5'd0, 64'd0, 64'd0, 1);
    chk_out("st_idle", 1'b0, 5'd0, 64'd0, 1'b0);
    // reset after the low write of a widening pair
    step(1, 1, 5'd20, 64'h77, 64'h88, 1);
    step(0, 0, 5'd0, 64'd0, 64'd0, 1);
    chk_out("mr_low", 1'b1, 5'd20, 64'h77, 1'b0);
    @(posedge clock);
    #1 reset_n = 1'b0;
    @(negedge clock);
    chk_out("mr_reset", 1'b0, 5'd0, 64'd0, 1'b0);
`ifdef DRAGONFANG_WRITEBACK_COUNTER_EN
    chk("mr_count", {32'd0, write_count}, 64'd0);
`endif
    @(posedge clock);
    #1 reset_n = 1'b1;
    step(0, 0, 5'd0, 64'd0, 64'd0, 1);
    chk_out("mr_after", 1'b0, 5'd0, 64'd0, 1'b0);
    // randomized traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, 5'($urandom),
           {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 9) < 7);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vector_floating_point_writeback_stage.md
# vector_floating_point_writeback_stage

Registered writeback stage directly downstream of the vector floating-point multiply unit. Captures one multiply result per accepted transaction and serialises it into 64-bit vector register file writes: one write for 64-bit or non-widening 32-bit results, two writes (low then high) for widening 32→64-bit results. Valid/ready handshakes on both sides decouple the combinational multiplier from register file back-pressure.

## Interface
Parameters:
- ADDRESS_WIDTH, 5, vector register index width (32 registers).

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  multiply result present.
- in_ready  output  1  stage accepts result this cycle.
- in_widening  input  1  result is widening (vd and vd_high both meaningful).
- in_vd_index  input  ADDRESS_WIDTH  destination register of low half.
- vd  input  64  multiply unit low/only result.
- vd_high  input  64  multiply unit high result (widening only; ignored otherwise).
- out_valid  output  1  register file write request.
- out_ready  input  1  register file accepts write.
- out_address  output  ADDRESS_WIDTH  write register index.
- out_data  output  64  write data.
- out_last  output  1  current write completes the transaction.

## Operation
- Holding registers: data_low, data_high, index, widening; loaded only on input handshake (in_valid & in_ready).
- States: IDLE, EMIT_LOW, EMIT_HIGH.
- IDLE: in_ready=1, out_valid=0. On accept → EMIT_LOW.
- EMIT_LOW: out_valid=1, out_data=data_low, out_address=index, out_last=!widening.
  - out_ready & widening → EMIT_HIGH.
  - out_ready & !widening: accept new input if in_valid (→ EMIT_LOW with new data), else → IDLE.
  - !out_ready: hold all outputs stable.
- EMIT_HIGH: out_valid=1, out_data=data_high, out_address=index+1 modulo 2^ADDRESS_WIDTH (31 wraps to 0), out_last=1.
  - out_ready: accept new input if in_valid (→ EMIT_LOW), else → IDLE.
- in_ready = IDLE | (EMIT_LOW & !widening & out_ready) | (EMIT_HIGH & out_ready); combinational from state and out_ready, no path from in_valid.
- vd_high never written when held widening=0.
- out_* driven to 0 in IDLE.

## Timing
- Reset: state IDLE, out_valid 0, out_data 0, out_address 0, out_last 0, holding registers 0, counter 0.
- Latency: accepted result appears on out_* the following cycle.
- Throughput: one non-widening transaction per cycle; widening transaction occupies two output cycles minimum.
- Output stable while out_valid & !out_ready.
- Simultaneous final-write handshake and input accept: new data visible next cycle, no bubble.
- reset_n asserted mid-transaction: held data discarded, no further writes issued.

## Configuration
- DRAGONFANG_WRITEBACK_COUNTER_EN defined: adds output write_count (32 bits), incremented on every out_valid & out_ready, wraps 0xFFFFFFFF→0, cleared by reset.
- Undefined: port and counter absent; behaviour otherwise identical.

## Test plan
- Non-widening: accept vd=0x3FF0000000000000, index 3, out_ready=1 → next cycle one write addr 3 data 0x3FF0000000000000 out_last=1, then IDLE.
- Widening: vd=0x4000000000000000, vd_high=0x4008000000000000, index 6 → writes addr 6 then addr 7, out_last 0 then 1; in_ready 0 during first write.
- Back-pressure: out_ready=0 for 3 cycles in EMIT_HIGH → outputs unchanged, in_ready=0; release → write completes, new input accepted same cycle.
- Wrap: widening with index 31 → second write addr 0.
- Streaming: 4 back-to-back non-widening inputs, out_ready=1 → 4 writes on 4 consecutive cycles, in_ready held 1.
- Reset mid-widening after low write → no high write, out_valid 0, write_count 0 (with DRAGONFANG_WRITEBACK_COUNTER_EN).
